// File: rtl/div_mon_pkg.sv
// div_mon_pkg: shared types and helpers for the divided-clock ratio monitor.
package div_mon_pkg;

  // Monitor FSM: waiting for a first edge, acquiring good periods, locked.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } mon_state_t;

  // Saturating increment on a 32-bit carrier; callers cast back to their width.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

  // A phase with no edge for this many half-cycles is treated as a stuck input.
  function automatic int unsigned timeout_len(input int unsigned div_ratio);
    return 32'd4 * div_ratio;
  endfunction

endpackage

// File: rtl/div_edge_sampler.sv
// div_edge_sampler: dual-edge sampler for div_in.
// Presents, after every posedge, the ordered pair (s_n, s_p): the value seen at
// the preceding negedge followed by the value seen at that posedge.
module div_edge_sampler (
  input  logic clk,
  input  logic reset,
  input  logic div_in,
  output logic s_n,
  output logic s_p
);

  logic neg_reg;
  logic s_n_reg;
  logic s_p_reg;

  // Capture div_in on the falling clock edge.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      neg_reg <= 1'b0;
    end else begin
      neg_reg <= div_in;
    end
  end

  // Re-time the negedge sample next to the posedge sample so both land together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_n_reg <= 1'b0;
      s_p_reg <= 1'b0;
    end else begin
      s_n_reg <= neg_reg;
      s_p_reg <= div_in;
    end
  end

  assign s_n = s_n_reg;
  assign s_p = s_p_reg;

endmodule

// File: rtl/div_ratio_monitor.sv
// div_ratio_monitor: measures high/low phases of a divided clock in half-cycle
// units, tracks lock against DIV_RATIO and raises sticky fault/stuck flags.
// Optional saturating error counter output err_cnt is enabled by the macro
// DIV_MON_ERRCNT_EN.
module div_ratio_monitor
  import div_mon_pkg::*;
#(
  parameter int DIV_RATIO = 9,
  parameter int LOCK_CNT  = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic             clr_fault,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic             meas_valid,
  output logic             lock,
  output logic             fault,
  output logic             stuck,
`ifdef DIV_MON_ERRCNT_EN
  output logic [7:0]       err_cnt,
`endif
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] RUN_MAX     = '1;
  localparam logic [CNT_W-1:0] DIV_LEN     = CNT_W'(DIV_RATIO);
  localparam logic [CNT_W-1:0] TIMEOUT_LEN = CNT_W'(timeout_len(DIV_RATIO));

  // Complete measurement context; one copy per half-cycle sample step.
  typedef struct packed {
    mon_state_t       st;
    logic [CNT_W-1:0] run;
    logic             prev;
    logic [CNT_W-1:0] hold_h;
    logic             hold_v;
    logic [GW-1:0]    good;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] low;
    logic             meas;
    logic             bad_lock;
    logic             tmo;
  } ctx_t;

  // Power pins carry no logic.
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  logic s_n;
  logic s_p;

  mon_state_t       state_reg;
  logic [CNT_W-1:0] run_reg;
  logic             prev_reg;
  logic [CNT_W-1:0] hold_h_reg;
  logic             hold_v_reg;
  logic [GW-1:0]    good_reg;
  logic [CNT_W-1:0] high_len_reg;
  logic [CNT_W-1:0] low_len_reg;
  logic             meas_valid_reg;
  logic             fault_reg;
  logic             stuck_reg;

  ctx_t ctx_cur;
  ctx_t ctx_mid;
  ctx_t ctx_end;

  logic fault_event;
  logic fault_next;
  logic stuck_next;

  div_edge_sampler u_sampler (
    .clk    (clk),
    .reset  (reset),
    .div_in (div_in),
    .s_n    (s_n),
    .s_p    (s_p)
  );

  // Advance the context by one half-cycle sample x.
  function automatic ctx_t step_sample(input ctx_t c, input logic x);
    ctx_t             r;
    logic [CNT_W-1:0] len;
    logic             good;
    r    = c;
    len  = c.run;
    good = 1'b0;
    if (x == c.prev) begin
      r.run = CNT_W'(sat_inc(32'(c.run), 32'(RUN_MAX)));
      // Equality fires once: run passes the threshold exactly by single steps.
      if (r.run == TIMEOUT_LEN) begin
        r.tmo    = 1'b1;
        r.st     = ST_IDLE;
        r.hold_v = 1'b0;
        r.good   = '0;
      end
    end else begin
      r.run  = CNT_W'(1);
      r.prev = x;
      if (c.st == ST_IDLE) begin
        // First edge after idle: the partial phase before it is meaningless.
        r.st     = ST_ACQ;
        r.hold_v = 1'b0;
        r.good   = '0;
      end else if (!x) begin
        r.hold_h = len;
        r.hold_v = 1'b1;
      end else if (c.hold_v) begin
        r.high = c.hold_h;
        r.low  = len;
        r.meas = 1'b1;
        good   = (c.hold_h == DIV_LEN) && (len == DIV_LEN);
        if (c.st == ST_ACQ) begin
          if (good) begin
            r.good = GW'(sat_inc(32'(c.good), $unsigned(LOCK_CNT)));
            if (r.good == GW'(LOCK_CNT)) begin
              r.st = ST_LOCK;
            end
          end else begin
            r.good = '0;
          end
        end else if (c.st == ST_LOCK && !good) begin
          r.bad_lock = 1'b1;
          r.good     = '0;
          r.st       = ST_ACQ;
        end
      end
    end
    return r;
  endfunction

  assign ctx_cur = '{
    st:       state_reg,
    run:      run_reg,
    prev:     prev_reg,
    hold_h:   hold_h_reg,
    hold_v:   hold_v_reg,
    good:     good_reg,
    high:     high_len_reg,
    low:      low_len_reg,
    meas:     1'b0,
    bad_lock: 1'b0,
    tmo:      1'b0
  };

  // The negedge sample is older than the posedge sample, so it goes first.
  assign ctx_mid = step_sample(ctx_cur, s_n);
  assign ctx_end = step_sample(ctx_mid, s_p);

  // Sticky flags: a clear drops the old value but never masks a new event.
  always_comb begin
    fault_event = 1'b0;
    fault_next  = fault_reg;
    stuck_next  = stuck_reg;
    fault_event = ctx_end.bad_lock | ctx_end.tmo;
    fault_next  = (fault_reg & ~clr_fault) | fault_event;
    stuck_next  = (stuck_reg & ~clr_fault) | ctx_end.tmo;
  end

  // Register the measurement context and outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      run_reg        <= '0;
      prev_reg       <= 1'b0;
      hold_h_reg     <= '0;
      hold_v_reg     <= 1'b0;
      good_reg       <= '0;
      high_len_reg   <= '0;
      low_len_reg    <= '0;
      meas_valid_reg <= 1'b0;
      fault_reg      <= 1'b0;
      stuck_reg      <= 1'b0;
    end else begin
      state_reg      <= ctx_end.st;
      run_reg        <= ctx_end.run;
      prev_reg       <= ctx_end.prev;
      hold_h_reg     <= ctx_end.hold_h;
      hold_v_reg     <= ctx_end.hold_v;
      good_reg       <= ctx_end.good;
      high_len_reg   <= ctx_end.high;
      low_len_reg    <= ctx_end.low;
      meas_valid_reg <= ctx_end.meas;
      fault_reg      <= fault_next;
      stuck_reg      <= stuck_next;
    end
  end

`ifdef DIV_MON_ERRCNT_EN
  logic [7:0] err_cnt_reg;

  // Count locked bad periods and timeouts; with a simultaneous clear only the new event remains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_reg <= '0;
    end else if (clr_fault) begin
      err_cnt_reg <= {7'd0, fault_event};
    end else if (fault_event) begin
      err_cnt_reg <= 8'(sat_inc(32'(err_cnt_reg), 32'd255));
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

  assign high_len   = high_len_reg;
  assign low_len    = low_len_reg;
  assign meas_valid = meas_valid_reg;
  assign lock       = (state_reg == ST_LOCK);
  assign fault      = fault_reg;
  assign stuck      = stuck_reg;

endmodule
